sobel_window_gen: RTL and testbench

//  Builds 3x3 pixel neighbourhoods from a raster pixel stream, directly upstream of sobel_kernel.
//  Two line buffers plus a 3x3 register window present the 8 neighbours of each centre pixel on p0..p7.

---
 rtl/sobel_window_gen.sv | 176 +++++++++++++++++
 tb/tb_sobel_window_gen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// -----------------------------------------------------------------------------
// sobel_window_gen
//
// Builds 3x3 pixel neighbourhoods from a raster pixel stream for sobel_kernel.
// Two line buffers hold the two previous lines. A 3x3 register window shifts
// one column per accepted pixel. The 8 neighbours of the centre pixel are
// presented on p0..p7. The centre pixel itself is not output.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-low
//   hc, vc     : column / row of pix_in (11 bit)
//   pix_in     : incoming pixel (PIX_W bits), raster order
//   pix_valid  : pix_in/hc/vc qualify this cycle
//   p0..p7     : TL, TC, TR, ML, MR, BL, BC, BR neighbours of the centre
//   win_valid  : one-cycle pulse; p0..p7, hc_out and vc_out hold a window
//   hc_out     : centre column (hc-1 of the completing pixel)
//   vc_out     : centre row    (vc-1 of the completing pixel)
//   win_count  : (only with WIN_COUNT_EN) windows emitted in current frame
//
// Handshake: pix_valid is a one-way qualifier with no ready. Every pixel with
// pix_valid=1 and hc<IMG_W is accepted in that cycle. A pixel with
// hc>=IMG_W is dropped without touching any state.
//
// Optional feature macro: WIN_COUNT_EN
// -----------------------------------------------------------------------------
module sobel_window_gen #(
  parameter int IMG_W = 640,
  parameter int PIX_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      hc,
  input  logic [10:0]      vc,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic [PIX_W-1:0] p0,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p4,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic             win_valid,
  output logic [10:0]      hc_out,
  output logic [10:0]      vc_out
`ifdef WIN_COUNT_EN
  ,
  output logic [31:0]      win_count
`endif
);

  localparam int          AW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [10:0] IMG_W_L = 11'(IMG_W);

  // Line buffers. lb0 holds the line two rows up, lb1 the line one row up.
  // Not reset; a window is only flagged valid once the rows have been filled.
  logic [PIX_W-1:0] lb0_q [IMG_W];
  logic [PIX_W-1:0] lb1_q [IMG_W];

  // Window: win_q[row][col]. Row 0 is top, col 0 is left, col 2 is right.
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];

  // Counts columns shifted in since reset or line start, saturating at 2.
  // A window is complete only when the two columns to the left of the
  // incoming one were also loaded after the last reset.
  logic [1:0]       fill_q, fill_d;
  logic             win_valid_q, win_valid_d;
  logic [10:0]      hc_out_q, hc_out_d;
  logic [10:0]      vc_out_q, vc_out_d;

  logic             accept;
  logic [AW-1:0]    addr;
  logic [PIX_W-1:0] rd0, rd1;

`ifdef WIN_COUNT_EN
  logic [31:0]      win_count_q, win_count_d;
`endif

  always_comb begin
    accept = pix_valid && (hc < IMG_W_L);
    addr   = hc[AW-1:0];
    // Read-before-write: these are the values held before this cycle's write.
    rd0    = lb0_q[addr];
    rd1    = lb1_q[addr];

    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = rd0;
      win_d[1][2] = rd1;
      win_d[2][2] = pix_in;
    end

    fill_d = fill_q;
    if (accept) begin
      if (hc == 11'd0) begin
        fill_d = 2'd1;
      end else if (fill_q != 2'd2) begin
        fill_d = fill_q + 2'd1;
      end
    end

    win_valid_d = accept && (hc >= 11'd2) && (vc >= 11'd2) && (fill_q == 2'd2);
    hc_out_d    = accept ? (hc - 11'd1) : hc_out_q;
    vc_out_d    = accept ? (vc - 11'd1) : vc_out_q;

`ifdef WIN_COUNT_EN
    // The start-of-frame clear has priority over an increment.
    win_count_d = win_count_q;
    if (accept && (hc == 11'd0) && (vc == 11'd0)) begin
      win_count_d = 32'd0;
    end else if (win_valid_d) begin
      win_count_d = win_count_q + 32'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      fill_q      <= 2'd0;
      win_valid_q <= 1'b0;
      hc_out_q    <= 11'd0;
      vc_out_q    <= 11'd0;
`ifdef WIN_COUNT_EN
      win_count_q <= 32'd0;
`endif
    end else begin
      win_q       <= win_d;
      fill_q      <= fill_d;
      win_valid_q <= win_valid_d;
      hc_out_q    <= hc_out_d;
      vc_out_q    <= vc_out_d;
`ifdef WIN_COUNT_EN
      win_count_q <= win_count_d;
`endif
    end
  end

  // Line buffers shift down one row at the accepted column.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[addr] <= lb1_q[addr];
      lb1_q[addr] <= pix_in;
    end
  end

  // The window registers are the output registers, so p0..p7 hold their
  // value whenever no pixel is accepted.
  assign p0 = win_q[0][0];
  assign p1 = win_q[0][1];
  assign p2 = win_q[0][2];
  assign p3 = win_q[1][0];
  assign p4 = win_q[1][2];
  assign p5 = win_q[2][0];
  assign p6 = win_q[2][1];
  assign p7 = win_q[2][2];

  assign win_valid = win_valid_q;
  assign hc_out    = hc_out_q;
  assign vc_out    = vc_out_q;
`ifdef WIN_COUNT_EN
  assign win_count = win_count_q;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// -----------------------------------------------------------------------------
// tb_sobel_window_gen
//
// Directed bench for sobel_window_gen with an 8-pixel-wide image and 4 rows.
// Pixel (x,y) is encoded as {8'(y), 8'(x), 8'h00}. This lets the expected
// window for any centre be written directly from its coordinates.
// -----------------------------------------------------------------------------
module tb_sobel_window_gen;

  localparam int IMG_W = 8;
  localparam int PIX_W = 24;
  localparam int ROWS  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [10:0]      hc = '0;
  logic [10:0]      vc = '0;
  logic [PIX_W-1:0] pix_in = '0;
  logic             pix_valid = 1'b0;
  logic [PIX_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7;
  logic             win_valid;
  logic [10:0]      hc_out, vc_out;
`ifdef WIN_COUNT_EN
  logic [31:0]      win_count;
  int               exp_cnt = 0;
`endif

  logic [8*PIX_W-1:0] p_all;
  assign p_all = {p0, p1, p2, p3, p4, p5, p6, p7};

  int errors = 0;
  int checks = 0;

  sobel_window_gen #(.IMG_W(IMG_W), .PIX_W(PIX_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .hc        (hc),
    .vc        (vc),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .p0        (p0),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3),
    .p4        (p4),
    .p5        (p5),
    .p6        (p6),
    .p7        (p7),
    .win_valid (win_valid),
    .hc_out    (hc_out),
    .vc_out    (vc_out)
`ifdef WIN_COUNT_EN
    ,
    .win_count (win_count)
`endif
  );

  // golden pixel / window
  function automatic logic [PIX_W-1:0] pix(input int x, input int y);
    logic [7:0] xb, yb;
    xb = x[7:0];
    yb = y[7:0];
    return {yb, xb, 8'h00};
  endfunction

  function automatic logic [8*PIX_W-1:0] exp_win(input int cx, input int cy);
    return {pix(cx-1, cy-1), pix(cx, cy-1), pix(cx+1, cy-1),
            pix(cx-1, cy),                  pix(cx+1, cy),
            pix(cx-1, cy+1), pix(cx, cy+1), pix(cx+1, cy+1)};
  endfunction

  // driver tasks: drive on negedge, sample 1 time unit after posedge
  task automatic drive(input logic v, input int x, input int y, input logic [PIX_W-1:0] d);
    @(negedge clk);
    pix_valid = v;
    hc        = 11'(x);
    vc        = 11'(y);
    pix_in    = d;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    pix_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Sends one 8x4 frame and checks every cycle. toggle inserts an idle cycle
  // after every pixel. inject drives an out-of-range pixel before (3,2).
  // stop_x/stop_y end the frame early after that pixel (-1: full frame).
  task automatic send_frame(input bit toggle, input bit inject,
                            input int stop_x, input int stop_y,
                            output int pulses);
    bit exp_v;
    pulses = 0;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        if (inject && x == 3 && y == 2) begin
          drive(1'b1, 9, 2, 24'hABCDEF);
          checks++;
          if (win_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignored_hc_valid: win_valid=%0b want 0", win_valid);
          end
          checks++;
          if (p_all !== exp_win(1, 1)) begin
            errors++;
            $display("FAIL ignored_hc_hold: p=%h want %h", p_all, exp_win(1, 1));
          end
        end
        drive(1'b1, x, y, pix(x, y));
        exp_v = (x >= 2) && (y >= 2);
        checks++;
        if (win_valid !== exp_v) begin
          errors++;
          $display("FAIL win_valid(%0d,%0d): got %0b want %0b", x, y, win_valid, exp_v);
        end
        if (win_valid === 1'b1) pulses++;
        if (exp_v) begin
          checks++;
          if (p_all !== exp_win(x-1, y-1)) begin
            errors++;
            $display("FAIL window(%0d,%0d): got %h want %h", x-1, y-1, p_all, exp_win(x-1, y-1));
          end
          checks++;
          if (hc_out !== 11'(x-1) || vc_out !== 11'(y-1)) begin
            errors++;
            $display("FAIL centre_coord: got (%0d,%0d) want (%0d,%0d)", hc_out, vc_out, x-1, y-1);
          end
        end
`ifdef WIN_COUNT_EN
        if (x == 0 && y == 0) exp_cnt = 0;
        else if (exp_v) exp_cnt++;
        checks++;
        if (win_count !== 32'(exp_cnt)) begin
          errors++;
          $display("FAIL win_count(%0d,%0d): got %0d want %0d", x, y, win_count, exp_cnt);
        end
`endif
        if (toggle) begin
          idle();
          checks++;
          if (win_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid(%0d,%0d): got %0b want 0", x, y, win_valid);
          end
          if (exp_v) begin
            checks++;
            if (p_all !== exp_win(x-1, y-1)) begin
              errors++;
              $display("FAIL idle_hold(%0d,%0d): got %h want %h", x-1, y-1, p_all, exp_win(x-1, y-1));
            end
          end
        end
        if (x == stop_x && y == stop_y) return;
      end
    end
  endtask

  task automatic check_pulses(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: pulses=%0d want %0d", name, got, want);
    end
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if (p_all !== '0 || win_valid !== 1'b0 || hc_out !== 11'd0 || vc_out !== 11'd0) begin
      errors++;
      $display("FAIL %s: p=%h win_valid=%0b hc_out=%0d vc_out=%0d want all 0",
               name, p_all, win_valid, hc_out, vc_out);
    end
`ifdef WIN_COUNT_EN
    checks++;
    if (win_count !== 32'd0) begin
      errors++;
      $display("FAIL %s_count: got %0d want 0", name, win_count);
    end
`endif
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b0;
    pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset_state");
    @(negedge clk);
    reset = 1'b1;
    idle();
    check_cleared("post_reset_idle");
  endtask

  task automatic test_frame_continuous();
    int n;
    send_frame(1'b0, 1'b0, -1, -1, n);
    check_pulses("continuous_pulses", n, 12);
  endtask

  task automatic test_toggle();
    int n;
    send_frame(1'b1, 1'b0, -1, -1, n);
    check_pulses("toggle_pulses", n, 12);
  endtask

  task automatic test_ignore_hc();
    int n;
    send_frame(1'b0, 1'b1, -1, -1, n);
    check_pulses("ignore_hc_pulses", n, 12);
  endtask

  task automatic test_reset_midline();
    int n;
    send_frame(1'b0, 1'b0, 4, 2, n);
    check_pulses("pre_reset_pulses", n, 3);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("midline_reset");
    @(negedge clk);
    reset = 1'b1;
`ifdef WIN_COUNT_EN
    exp_cnt = 0;
`endif
    send_frame(1'b0, 1'b0, -1, -1, n);
    check_pulses("post_reset_pulses", n, 12);
  endtask

`ifdef WIN_COUNT_EN
  task automatic test_win_count();
    int n;
    send_frame(1'b0, 1'b0, -1, -1, n);
    checks++;
    if (win_count !== 32'd12) begin
      errors++;
      $display("FAIL count_frame1: got %0d want 12", win_count);
    end
    send_frame(1'b0, 1'b0, -1, -1, n);
    checks++;
    if (win_count !== 32'd12) begin
      errors++;
      $display("FAIL count_frame2: got %0d want 12", win_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_continuous();
    test_toggle();
    test_ignore_hc();
    test_reset_midline();
`ifdef WIN_COUNT_EN
    test_win_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
